// File: rtl/spw_sw_pkg.sv
// Shared definitions for the SpaceWire switch egress path: character
// width, control-character encodings and the egress reader state enum.
package spw_sw_pkg;

  localparam int DW  = 8;
  localparam int CHW = DW + 1;

  // Control characters carry bit DW = 1; bit 0 selects EOP (0) or EEP (1).
  localparam logic [CHW-1:0] EOP_CHAR = {1'b1, {(DW - 1){1'b0}}, 1'b0};
  localparam logic [CHW-1:0] EEP_CHAR = {1'b1, {(DW - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PKT     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  function automatic logic is_eop(input logic [CHW-1:0] c);
    return c[CHW-1] & ~c[0];
  endfunction

  function automatic logic is_eep(input logic [CHW-1:0] c);
    return c[CHW-1] & c[0];
  endfunction

endpackage

// File: rtl/egress_buf2.sv
// Two-entry skid buffer behind a one-cycle-latency FIFO read port.
// Counts the read in flight together with stored entries so that the
// upstream read strobe can never overrun the two slots.
module egress_buf2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd,         // read issued to the FIFO this cycle
  input  logic         flush,      // drop stored entries and the read in flight
  input  logic         drop,       // discard the returning character
  input  logic         pop,        // head consumed this cycle
  input  logic [W-1:0] wdata,      // FIFO data, valid the cycle after rd
  output logic         space,      // another read may be issued this cycle
  output logic         inflight,   // wdata carries a returned character
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic         term_held   // a control char is stored or returning
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop_ok;
  logic [1:0]   occ_after;

  assign push       = inflight & ~flush & ~drop;
  assign head_valid = (count != 2'd0);
  assign pop_ok     = pop & head_valid;
  assign head_data  = mem[rd_ptr];
  // A pop in this cycle frees its slot in time for the next return, which
  // is what lets the reader sustain one character per cycle.
  assign occ_after  = count - {1'b0, pop_ok};
  assign space      = (occ_after + {1'b0, inflight}) < 2'd2;
  // The top bit of a character is its control flag.
  assign term_held  = (head_valid & mem[rd_ptr][W-1])
                    | ((count == 2'd2) & mem[~rd_ptr][W-1])
                    | (inflight & wdata[W-1]);

  // Pointer, occupancy and in-flight bookkeeping.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else if (flush) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= rd;
      if (push)   wr_ptr <= ~wr_ptr;
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop_ok};
    end
  end

  // Character storage.
  // NOTE: storage is deliberately not reset; count gates every read of it,
  // so leaving it reset-free keeps the array as plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/switch_egress_port.sv
// Egress reader for one switch output port: drains the port FIFO into a
// valid/ready stream for the CODEC transmitter, tracks packet boundaries
// and terminates stalled packets with an injected EEP.
module switch_egress_port
  import spw_sw_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 16
) (
  input  logic            gclk,
  input  logic            reset,
  input  logic            empty_i,
  output logic            rd_o,
  input  logic [CHW-1:0]  din,
  input  logic            active_i,
  output logic [CHW-1:0]  tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic            busy_o,
  output logic            timeout_o,
  output logic [CNTW-1:0] pkt_cnt_o
);

  localparam int            SW          = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX  = SW'(TIMEOUT);
  localparam logic [SW-1:0] STARVE_LAST = SW'(TIMEOUT - 1);

  state_t         state, state_d;
  logic [SW-1:0]  starve_cnt;
  logic           inject_pending;
  logic           space, inflight, head_valid, term_held;
  logic [CHW-1:0] head_data, xfer_char;
  logic           xfer, xfer_term, din_term, starving, fire;

  assign rd_o       = ~reset & ~empty_i & active_i & ~inject_pending & space;
  assign tx_valid_o = active_i & (inject_pending | head_valid);
  // The buffer is always empty while an injected EEP is pending.
  assign xfer_char  = inject_pending ? EEP_CHAR : head_data;
  assign tx_data_o  = tx_valid_o ? xfer_char : '0;
  assign xfer       = tx_valid_o & tx_ready_i;
  assign xfer_term  = is_eop(xfer_char) | is_eep(xfer_char);
  assign din_term   = is_eop(din) | is_eep(din);
  // Starved: inside a packet with nothing stored, returning or available.
  assign starving   = (state == PKT) & empty_i & ~head_valid & ~inflight;
  assign fire       = starving & active_i & (starve_cnt == STARVE_LAST);
  assign timeout_o  = fire;
  assign busy_o     = (state == PKT);

  egress_buf2 #(.W(CHW)) u_buf (
    .clk        (gclk),
    .rst        (reset),
    .rd         (rd_o),
    .flush      (~active_i),
    .drop       (state == DISCARD),
    .pop        (xfer & ~inject_pending),
    .wdata      (din),
    .space      (space),
    .inflight   (inflight),
    .head_valid (head_valid),
    .head_data  (head_data),
    .term_held  (term_held)
  );

  // Next-state logic for the packet-boundary FSM.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (xfer && !xfer_term) state_d = PKT;
      end
      PKT: begin
        // A flushed terminator means the packet already ended upstream of
        // the link; discarding would eat the start of the next packet.
        if (!active_i)              state_d = term_held ? IDLE : DISCARD;
        else if (xfer && xfer_term) state_d = IDLE;
        else if (fire)              state_d = DISCARD;
      end
      DISCARD: begin
        if (active_i && inflight && din_term) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, starvation counter, EEP injection and packet counter.
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      inject_pending <= 1'b0;
      pkt_cnt_o      <= '0;
    end else begin
      state <= state_d;
      if (!starving)                     starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
      if (!active_i)                     inject_pending <= 1'b0;
      else if (fire)                     inject_pending <= 1'b1;
      else if (xfer && inject_pending)   inject_pending <= 1'b0;
      if (xfer && xfer_term)             pkt_cnt_o <= pkt_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_egress_port.sv
// Self-checking bench for switch_egress_port: cycle table for the basic
// stream, hand-written timeout / link-loss / reset sequences and a random
// packet stream compared against an expected character list.
module tb_switch_egress_port;
  import spw_sw_pkg::*;

  localparam int TO = 16;

  logic            gclk, reset, empty_i, rd_o, active_i;
  logic [CHW-1:0]  din, tx_data_o;
  logic            tx_valid_o, tx_ready_i, busy_o, timeout_o;
  logic [15:0]     pkt_cnt_o;

  switch_egress_port #(.TIMEOUT(TO), .CNTW(16)) dut (
    .gclk       (gclk),
    .reset      (reset),
    .empty_i    (empty_i),
    .rd_o       (rd_o),
    .din        (din),
    .active_i   (active_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o),
    .pkt_cnt_o  (pkt_cnt_o)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct {
    logic           ready;
    logic           rd;
    logic           valid;
    logic [CHW-1:0] data;
    logic           busy;
    logic [15:0]    cnt;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [CHW-1:0] q[$];       // switch FIFO contents
  logic [CHW-1:0] out_q[$];   // characters delivered to the CODEC
  logic [CHW-1:0] exp_q[$];   // expected delivered characters
  bit             hold_empty;
  int             cyc, reads, xfers, bp_viol, to_cnt, to_cyc, exp_cnt, t0;
  logic           s_rd, s_valid, s_busy, s_to;
  logic [CHW-1:0] s_data;
  logic [15:0]    s_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: present FIFO state, sample outputs mid-cycle, emulate
  // the FIFO's one-cycle read latency after the edge.
  task automatic tick();
    bit do_read;
    empty_i = (q.size() == 0) || hold_empty;
    #1;
    s_rd = rd_o; s_valid = tx_valid_o; s_data = tx_data_o;
    s_busy = busy_o; s_to = timeout_o; s_cnt = pkt_cnt_o;
    do_read = rd_o;
    if (tx_valid_o && tx_ready_i) begin
      out_q.push_back(tx_data_o);
      xfers++;
    end
    if (rd_o) reads++;
    if (reads - xfers > 2) bp_viol++;
    if (timeout_o) begin
      to_cnt++;
      to_cyc = cyc;
    end
    @(posedge gclk);
    #1;
    if (do_read) din = q.pop_front();
    else         din = CHW'($urandom);
    @(negedge gclk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic compare_out(input string name);
    check({name, ".len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), out_q[i], exp_q[i]);
  endtask

  vec_t tbl[7];

  initial begin
    reset = 1'b1; empty_i = 1'b0; active_i = 1'b1; tx_ready_i = 1'b1;
    din = '0; hold_empty = 0; cyc = 0; exp_cnt = 0; to_cnt = 0; to_cyc = -1;
    reads = 0; xfers = 0; bp_viol = 0;

    // Reset values, with empty_i low so rd_o is held off by reset alone.
    @(negedge gclk); #1;
    check("rst.rd",    rd_o, 0);
    check("rst.valid", tx_valid_o, 0);
    check("rst.data",  tx_data_o, 0);
    check("rst.busy",  busy_o, 0);
    check("rst.to",    timeout_o, 0);
    check("rst.cnt",   pkt_cnt_o, 0);
    empty_i = 1'b1;
    @(negedge gclk); reset = 1'b0;
    @(negedge gclk);

    // Basic stream: cycle-by-cycle expectations from empty_i falling.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 9'h000,   1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 9'h000,   1'b0, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 9'h011,   1'b0, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 9'h022,   1'b1, 16'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 9'h033,   1'b1, 16'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, EOP_CHAR, 1'b1, 16'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 9'h000,   1'b0, 16'd1};
    q = '{9'h011, 9'h022, 9'h033, EOP_CHAR};
    for (int i = 0; i < 7; i++) begin
      tx_ready_i = tbl[i].ready;
      tick();
      check($sformatf("stream.rd[%0d]", i),    s_rd,    tbl[i].rd);
      check($sformatf("stream.valid[%0d]", i), s_valid, tbl[i].valid);
      if (tbl[i].valid) check($sformatf("stream.data[%0d]", i), s_data, tbl[i].data);
      check($sformatf("stream.busy[%0d]", i),  s_busy,  tbl[i].busy);
      check($sformatf("stream.cnt[%0d]", i),   s_cnt,   tbl[i].cnt);
    end
    exp_cnt = 1;

    // Backpressure: ready toggles every cycle over a 64-char packet.
    out_q.delete(); exp_q.delete(); reads = 0; xfers = 0; bp_viol = 0;
    for (int i = 0; i < 63; i++) exp_q.push_back({1'b0, 8'($urandom)});
    exp_q.push_back(EOP_CHAR);
    q = exp_q;
    for (int i = 0; i < 400 && out_q.size() < 64; i++) begin
      tx_ready_i = cyc[0];
      tick();
    end
    tx_ready_i = 1'b1;
    run(3);
    compare_out("bp");
    check("bp.outstanding_le_2", bp_viol, 0);
    exp_cnt++;
    check("bp.cnt", s_cnt, exp_cnt);

    // Timeout: one char then starvation; EEP after 16 starved cycles.
    out_q.delete(); exp_q.delete(); to_cnt = 0; to_cyc = -1;
    q = '{9'h0AA};
    for (int i = 0; i < 10 && out_q.size() == 0; i++) tick();
    t0 = cyc - 1;
    run(20);
    check("to.pulses", to_cnt, 1);
    check("to.cycle",  to_cyc - t0, TO);
    check("to.busy",   s_busy, 0);
    exp_cnt++;
    check("to.cnt",    s_cnt, exp_cnt);
    q = '{9'h0BB, 9'h0CC, EOP_CHAR, 9'h001, EOP_CHAR};
    run(15);
    exp_q = '{9'h0AA, EEP_CHAR, 9'h001, EOP_CHAR};
    compare_out("to.out");
    exp_cnt++;
    check("to.cnt2",   s_cnt, exp_cnt);

    // Near-timeout: FIFO refills in the cycle the counter would expire.
    out_q.delete(); to_cnt = 0;
    q = '{9'h055};
    for (int i = 0; i < 10 && out_q.size() == 0; i++) tick();
    run(TO - 1);
    q = '{9'h066, EOP_CHAR};
    run(10);
    check("near.pulses", to_cnt, 0);
    exp_q = '{9'h055, 9'h066, EOP_CHAR};
    compare_out("near.out");
    exp_cnt++;
    check("near.cnt", s_cnt, exp_cnt);

    // Link loss mid-packet with two chars buffered.
    out_q.delete();
    q = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h0A5, EOP_CHAR};
    for (int i = 0; i < 10 && out_q.size() == 0; i++) tick();
    tx_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("link.hold_valid[%0d]", i), s_valid, 1);
      check($sformatf("link.hold_data[%0d]", i),  s_data, 9'h0A2);
    end
    check("link.rd_full", s_rd, 0);
    active_i = 1'b0;
    tick();
    check("link.valid_low", s_valid, 0);
    check("link.rd_low",    s_rd, 0);
    run(3);
    check("link.busy_low",  s_busy, 0);
    active_i = 1'b1; tx_ready_i = 1'b1;
    q.push_back(9'h0B1); q.push_back(9'h0B2); q.push_back(EOP_CHAR);
    run(20);
    exp_q = '{9'h0A1, 9'h0B1, 9'h0B2, EOP_CHAR};
    compare_out("link.out");
    exp_cnt++;
    check("link.cnt", s_cnt, exp_cnt);

    // Random packets with random FIFO gaps and random backpressure.
    out_q.delete(); exp_q.delete();
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 6) != 0) begin
        int len = $urandom_range(1, 8);
        for (int i = 0; i < len; i++) exp_q.push_back({1'b0, 8'($urandom)});
      end
      exp_q.push_back($urandom_range(0, 1) ? EEP_CHAR : EOP_CHAR);
      exp_cnt++;
    end
    q = exp_q;
    for (int i = 0; i < 4000 && (out_q.size() < exp_q.size()); i++) begin
      tx_ready_i = ($urandom_range(0, 9) < 7);
      hold_empty = ($urandom_range(0, 3) == 0);
      tick();
    end
    hold_empty = 0; tx_ready_i = 1'b1;
    run(5);
    compare_out("rand");
    check("rand.cnt", s_cnt, exp_cnt);

    // Asynchronous reset mid-packet while a char is presented.
    q = '{9'h071, 9'h072, 9'h073};
    tx_ready_i = 1'b0;
    run(4);
    check("arst.pre_valid", s_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("arst.rd",    rd_o, 0);
    check("arst.valid", tx_valid_o, 0);
    check("arst.data",  tx_data_o, 0);
    check("arst.busy",  busy_o, 0);
    check("arst.to",    timeout_o, 0);
    check("arst.cnt",   pkt_cnt_o, 0);
    q.delete(); empty_i = 1'b1;
    @(negedge gclk); reset = 1'b0;
    @(negedge gclk);
    out_q.delete();
    tx_ready_i = 1'b1;
    q = '{9'h077, EOP_CHAR};
    run(8);
    exp_q = '{9'h077, EOP_CHAR};
    compare_out("post_rst");
    check("post_rst.cnt", s_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
